// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush control with blanking FSM, stall watchdog
// Optional perf counters (stall_cycles, flush_count) enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  ctrl_state,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [1:0]  ST_RUN    = 2'd0;
  localparam logic [1:0]  ST_BLANK  = 2'd1;
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] wd_cnt;
  logic [15:0] wd_next;
  logic        timeout_q;

  // Outputs are forced quiet while reset is asserted so no stage is held or killed.
  always_comb begin
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    state_next = ST_RUN;
    if (rst) begin
      case (state)
        ST_RUN: begin
          if (excepttype_i != 32'h0) begin
            flush      = 1'b1;
            new_pc     = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
            state_next = ST_BLANK;
          end else if (stallreq_from_mem) begin
            stall = 6'b011111;
          end else if (stallreq_from_ex) begin
            stall = 6'b001111;
          end else if (stallreq_from_id) begin
            stall = 6'b000111;
          end else if (stallreq_from_if) begin
            stall = 6'b000011;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    wd_next = 16'h0;
    if (stall != 6'b000000) begin
      wd_next = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_RUN;
      wd_cnt    <= 16'h0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_next;
      wd_cnt <= wd_next;
      if (32'(wd_next) >= STALL_LIMIT) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign ctrl_state    = state;
  assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 32'h0;
    end else begin
      if (stall != 6'b000000) begin
        stall_cycles_q <= stall_cycles_q + 32'h1;
      end
      if (flush) begin
        flush_count_q <= flush_count_q + 32'h1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl: vector table, corner sequences, random vs model
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
  logic        stall_timeout;
  logic [31:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (req_if),
    .stallreq_from_id (req_id),
    .stallreq_from_ex (req_ex),
    .stallreq_from_mem(req_mem),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .ctrl_state       (ctrl_state),
    .stall_timeout    (stall_timeout),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  typedef struct {
    logic        r;
    logic [3:0]  q;      // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [1:0]  e_state;
    logic        e_to;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for the falling edge (one rising edge after the previous call) and applies inputs.
  task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] exc, input logic [31:0] epc);
    @(negedge clk);
    rst          = r;
    req_mem      = q[3];
    req_ex       = q[2];
    req_id       = q[1];
    req_if       = q[0];
    excepttype_i = exc;
    cp0_epc_i    = epc;
    #1;
  endtask

  // Reference model state
  bit          m_blank;
  int unsigned m_wd;
  bit          m_to;
  logic [31:0] m_sc, m_fc;

  function automatic logic [5:0] prio_stall(input logic [3:0] q);
    if (q[3]) return 6'b011111;
    if (q[2]) return 6'b001111;
    if (q[1]) return 6'b000111;
    if (q[0]) return 6'b000011;
    return 6'b000000;
  endfunction

  initial begin
    logic [5:0]  x_stall;
    logic        x_flush;
    logic [31:0] x_pc;
    logic [3:0]  rq;
    logic [31:0] rexc, repc;
    logic        rr;

    vecs[0]  = '{1'b0, 4'b1111, 32'h0, 32'h0,          6'b000000, 1'b0, 32'h0,          2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0001, 32'h0, 32'h0,          6'b000011, 1'b0, 32'h0,          2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0101, 32'h0, 32'h0,          6'b001111, 1'b0, 32'h0,          2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 32'h0, 32'h0,          6'b011111, 1'b0, 32'h0,          2'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'b1000, 32'h8, 32'h0,          6'b000000, 1'b1, 32'h40,         2'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'b1000, 32'h0, 32'h0,          6'b000000, 1'b0, 32'h0,          2'd1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 32'h0, 32'h0,          6'b000000, 1'b0, 32'h0,          2'd0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0010, 32'he, 32'hBFC0_0100,  6'b000000, 1'b1, 32'hBFC0_0100,  2'd0, 1'b0};
    vecs[8]  = '{1'b1, 4'b0010, 32'he, 32'hBFC0_0100,  6'b000000, 1'b0, 32'h0,          2'd1, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 32'he, 32'hBFC0_0100,  6'b000000, 1'b1, 32'hBFC0_0100,  2'd0, 1'b0};
    vecs[10] = '{1'b1, 4'b0000, 32'h0, 32'h0,          6'b000000, 1'b0, 32'h0,          2'd1, 1'b0};
    vecs[11] = '{1'b1, 4'b0000, 32'h8, 32'h0,          6'b000000, 1'b1, 32'h40,         2'd0, 1'b0};
    vecs[12] = '{1'b0, 4'b0100, 32'h8, 32'h0,          6'b000000, 1'b0, 32'h0,          2'd1, 1'b0};
    vecs[13] = '{1'b1, 4'b0000, 32'h0, 32'h0,          6'b000000, 1'b0, 32'h0,          2'd0, 1'b0};

    rst = 1'b0; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
    excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    check("reset_state", 32'(ctrl_state), 32'd0);
    check("reset_timeout", 32'(stall_timeout), 32'd0);
    check("reset_stall_cycles", stall_cycles, 32'h0);
    check("reset_flush_count", flush_count, 32'h0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].r, vecs[i].q, vecs[i].exc, vecs[i].epc);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      check($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_pc);
      check($sformatf("vec%0d_state", i), 32'(ctrl_state), 32'(vecs[i].e_state));
      check($sformatf("vec%0d_timeout", i), 32'(stall_timeout), 32'(vecs[i].e_to));
    end

    // Watchdog: 15 stalled cycles stay below the limit, then 16 trip it.
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 4'b0100, 32'h0, 32'h0);
      check("wd_below_limit", 32'(stall_timeout), 32'd0);
    end
    drive(1'b1, 4'b0000, 32'h0, 32'h0);
    check("wd_after_15", 32'(stall_timeout), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'b0100, 32'h0, 32'h0);
      check("wd_counting", 32'(stall_timeout), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0000, 32'h0, 32'h0);
      check("wd_sticky", 32'(stall_timeout), 32'd1);
      check("wd_no_stall_effect", 32'(stall), 32'd0);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    drive(1'b1, 4'b0000, 32'h0, 32'h0);
    check("wd_cleared_by_reset", 32'(stall_timeout), 32'd0);

    // Perf: 10 stalled cycles and 2 exceptions.
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) drive(1'b1, 4'b0001, 32'h0, 32'h0);
    drive(1'b1, 4'b0000, 32'h8, 32'h0);
    drive(1'b1, 4'b0000, 32'h0, 32'h0);
    drive(1'b1, 4'b0000, 32'h8, 32'h0);
    drive(1'b1, 4'b0000, 32'h0, 32'h0);
    drive(1'b1, 4'b0000, 32'h0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_cycles", stall_cycles, 32'd10);
    check("perf_flush_count", flush_count, 32'd2);
`else
    check("perf_stall_cycles", stall_cycles, 32'd0);
    check("perf_flush_count", flush_count, 32'd0);
`endif

    // Random stimulus against the reference model.
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    m_blank = 0; m_wd = 0; m_to = 0; m_sc = 0; m_fc = 0;
    for (int c = 0; c < 3000; c++) begin
      rr   = ($urandom_range(0, 99) != 0);
      rq   = ($urandom_range(0, 3) == 0) ? 4'b0100 : 4'($urandom);
      rexc = 32'h0;
      if ($urandom_range(0, 7) == 0) rexc = ($urandom_range(0, 1) != 0) ? 32'he : $urandom;
      repc = $urandom;
      drive(rr, rq, rexc, repc);

      x_stall = 6'b0; x_flush = 1'b0; x_pc = 32'h0;
      if (rr && !m_blank) begin
        if (rexc != 0) begin
          x_flush = 1'b1;
          x_pc    = (rexc == 32'he) ? repc : 32'h40;
        end else begin
          x_stall = prio_stall(rq);
        end
      end
      check("rnd_stall", 32'(stall), 32'(x_stall));
      check("rnd_flush", 32'(flush), 32'(x_flush));
      check("rnd_new_pc", new_pc, x_pc);
      check("rnd_state", 32'(ctrl_state), m_blank ? 32'd1 : 32'd0);
      check("rnd_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef PIPE_CTRL_PERF_EN
      check("rnd_stall_cycles", stall_cycles, m_sc);
      check("rnd_flush_count", flush_count, m_fc);
`else
      check("rnd_stall_cycles", stall_cycles, 32'h0);
      check("rnd_flush_count", flush_count, 32'h0);
`endif

      if (!rr) begin
        m_blank = 0; m_wd = 0; m_to = 0; m_sc = 0; m_fc = 0;
      end else begin
        m_blank = !m_blank && (rexc != 0);
        m_wd    = (x_stall != 0) ? ((m_wd < 65535) ? m_wd + 1 : m_wd) : 0;
        if (m_wd >= 16) m_to = 1;
        if (x_stall != 0) m_sc = m_sc + 1;
        if (x_flush) m_fc = m_fc + 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control block. It sits opposite the inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and drives their stall[5:0] and flush inputs.
- Arbitrates stall requests from IF, ID, EX and MEM.
- Turns an exception reported by MEM into a flush pulse and a new fetch PC.
- Sequences a post-flush blanking cycle, a stall watchdog and optional performance counters.

Parameters:
EXC_VECTOR, 32'h0000_0040, redirect PC for all non-ERET exceptions
STALL_LIMIT, 16, consecutive stalled cycles before stall_timeout sets (legal range 1..65535)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset; rst==0 at posedge resets
stallreq_from_if  input  1  IF stage stall request
stallreq_from_id  input  1  ID stage stall request
stallreq_from_ex  input  1  EX stage stall request (multi-cycle ALU, div)
stallreq_from_mem  input  1  MEM stage stall request
excepttype_i  input  32  exception code from MEM; 0 = none
cp0_epc_i  input  32  EPC from CP0, forwarded value
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  output  1  kill all inter-stage registers
new_pc  output  32  PC to load when flush==1
ctrl_state  output  2  current FSM state, debug
stall_timeout  output  1  sticky watchdog flag
stall_cycles  output  32  perf: cycles with stall!=0
flush_count  output  32  perf: number of flushes

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to RUN; watchdog counter, stall_timeout and perf counters clear to 0.
  - Outputs are combinational from state, so during reset: stall=0, flush=0, new_pc=0.
- FSM states: RUN=2'd0, BLANK=2'd1. Encoding 2'd2 and 2'd3 are illegal; either returns to RUN on the next cycle.
- RUN, excepttype_i==0:
  - flush=0, new_pc=0.
  - stall is combinational with 0-cycle latency, highest requester wins:
    - mem: 6'b011111
    - ex: 6'b001111
    - id: 6'b000111
    - if: 6'b000011
    - none: 6'b000000
- RUN, excepttype_i!=0:
  - flush=1 and stall=0 in the same cycle; flush overrides every stall request.
  - new_pc = cp0_epc_i if excepttype_i==32'h0000_000e (ERET), else EXC_VECTOR.
  - Next state is BLANK.
- BLANK (exactly one cycle):
  - flush=0, stall=0, new_pc=0.
  - excepttype_i and all stall requests are ignored, since those values come from killed instructions.
  - Next state is RUN unconditionally.
- Back-to-back exceptions: an exception present in BLANK is ignored. If it is still present in the following RUN cycle, it flushes then.
- Watchdog:
  - A 16-bit counter increments each cycle stall!=0 and clears on any cycle stall==0.
  - It saturates at 16'hFFFF.
  - When the counter reaches STALL_LIMIT, stall_timeout sets on that edge.
  - stall_timeout is cleared only by reset; stall output is unaffected by it.
- Reset mid-stall or mid-BLANK: the state returns to RUN immediately at the edge, and all counters clear.
- excepttype_i is an arbitrary 32-bit code; only its nonzero-ness and the ERET value matter.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - stall_cycles increments on every posedge where rst==1 and stall!=0.
  - flush_count increments on every posedge where rst==1 and flush==1.
  - Both wrap modulo 2^32.
- Undefined: no counter flops are built; stall_cycles and flush_count are tied to 32'h0.

Test Plan:
- Stall priority: after reset, drive if=1, then if=1/ex=1, then all four = 1 -> stall = 000011, then 001111, then 011111, with flush=0 throughout.
- Exception: excepttype_i=32'h8 while stallreq_from_mem=1 -> that cycle flush=1, stall=0, new_pc=32'h40, ctrl_state=0. Next cycle: ctrl_state=1, flush=0, stall=0. Cycle after: ctrl_state=0.
- ERET: cp0_epc_i=32'hBFC0_0100, excepttype_i=32'he -> flush=1, new_pc=32'hBFC0_0100. excepttype_i held 3 cycles -> flush pattern 1,0,1.
- Watchdog: STALL_LIMIT=16; hold stallreq_from_ex for 15 cycles -> stall_timeout=0. Drop for 1 cycle, then hold 16 cycles -> stall_timeout=1 after the 16th edge. Release -> stall_timeout stays 1 until rst=0.
- Reset mid-BLANK: rst=0 in the cycle after a flush -> next cycle ctrl_state=0, stall_timeout=0, counters=0.
- Perf (PIPE_CTRL_PERF_EN defined): 10 stalled cycles and 2 exceptions -> stall_cycles=10, flush_count=2. With the macro undefined, both read 0.
